// File: rtl/fifo_async_pkg.sv
// Shared definitions for the async FIFO write/read side logic:
// arbiter state encoding and a width-agnostic Gray-to-binary helper.
package fifo_async_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    // Widest pointer the helper supports; narrower pointers are zero-extended.
    localparam int GRAY_MAX_W = 32;

    // Zero-extended upper bits convert to zero, so one fixed-width routine
    // serves every pointer width up to GRAY_MAX_W.
    function automatic logic [GRAY_MAX_W-1:0] gray_to_bin(input logic [GRAY_MAX_W-1:0] g);
        logic [GRAY_MAX_W-1:0] b;
        b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
        for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester, FIFO write-side and status signals of the two-port write arbiter.
// master = arbiter, slave = requesters plus FIFO write-side logic.
interface fifo_wr_arbiter_if #(
    parameter int FIFO_addr_size = 4,
    parameter int DATA_W         = 16
);

    logic                    req0;
    logic                    req1;
    logic [DATA_W-1:0]       data0;
    logic [DATA_W-1:0]       data1;
    logic                    ack0;
    logic                    ack1;

    logic [FIFO_addr_size:0] w_pointer_gray;
    logic [FIFO_addr_size:0] r_pointer_gray_sync;
    logic                    full;
    logic                    w_en;
    logic [DATA_W-1:0]       w_data;

    logic                    busy;
    logic                    owner;

    modport master (
        input  req0, req1, data0, data1,
        input  w_pointer_gray, r_pointer_gray_sync, full,
        output ack0, ack1, w_en, w_data, busy, owner
    );

    modport slave (
        output req0, req1, data0, data1,
        output w_pointer_gray, r_pointer_gray_sync, full,
        input  ack0, ack1, w_en, w_data, busy, owner
    );

endinterface

// File: rtl/fifo_wr_arbiter_gray2bin.sv
// Combinational Gray-to-binary converter for one FIFO pointer.
module gray2bin
    import fifo_async_pkg::*;
#(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    if (WIDTH < 1 || WIDTH > GRAY_MAX_W) begin : g_bad_width
        $error("gray2bin: WIDTH %0d outside 1..%0d", WIDTH, GRAY_MAX_W);
    end

    assign bin = WIDTH'(gray_to_bin(GRAY_MAX_W'(gray)));

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter: grants one of two requesters a fixed-length burst
// into an async FIFO, only when the FIFO has room for the whole burst.
module fifo_wr_arbiter
    import fifo_async_pkg::*;
#(
    parameter int FIFO_addr_size = 4,
    parameter int DATA_W         = 16,
    parameter int BURST_LEN      = 8
) (
    input logic               clk_w,
    input logic               rst_w,
    fifo_wr_arbiter_if.master bus
);

    localparam int PTR_W = FIFO_addr_size + 1;
    localparam int DEPTH = 1 << FIFO_addr_size;

    if (BURST_LEN < 1 || BURST_LEN > DEPTH) begin : g_bad_burst
        $error("fifo_wr_arbiter: BURST_LEN %0d outside 1..%0d", BURST_LEN, DEPTH);
    end

    logic [PTR_W-1:0] wbin;
    logic [PTR_W-1:0] rbin;
    logic [PTR_W-1:0] used;
    logic [PTR_W-1:0] free;
    logic             burst_fits;

    gray2bin #(.WIDTH(PTR_W)) u_wbin (
        .gray (bus.w_pointer_gray),
        .bin  (wbin)
    );

    gray2bin #(.WIDTH(PTR_W)) u_rbin (
        .gray (bus.r_pointer_gray_sync),
        .bin  (rbin)
    );

    // Modular subtraction handles pointer wrap without special cases.
    assign used       = wbin - rbin;
    assign free       = PTR_W'(DEPTH) - used;
    assign burst_fits = (free >= PTR_W'(BURST_LEN));

    arb_state_t       state_q, state_d;
    logic [PTR_W-1:0] beat_q, beat_d;
    logic             owner_q, owner_d;
    logic             prio_q, prio_d;     // requester that wins the next tie
    logic             grant;
    logic             owner_req;
    logic             wr_en;

    assign grant     = (bus.req0 && bus.req1) ? prio_q : bus.req1;
    assign owner_req = owner_q ? bus.req1 : bus.req0;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_w or negedge rst_w) begin
        if (!rst_w) begin
            state_q <= IDLE;
            beat_q  <= '0;
            owner_q <= 1'b0;
            prio_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            owner_q <= owner_d;
            prio_q  <= prio_d;
        end
    end

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        owner_d = owner_q;
        prio_d  = prio_q;
        wr_en   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if ((bus.req0 || bus.req1) && burst_fits) begin
                    state_d = BURST;
                    beat_d  = '0;
                    owner_d = grant;
                    prio_d  = ~grant;
                end
            end

            BURST: begin
                if (!owner_req) begin
                    state_d = IDLE;
                end else if (!bus.full) begin
                    wr_en  = 1'b1;
                    beat_d = beat_q + 1'b1;
                    if (beat_q == PTR_W'(BURST_LEN - 1)) begin
                        state_d = IDLE;
                    end
                end
                // full while bursting: hold everything until space returns
            end

            default: state_d = IDLE;
        endcase
    end

    assign bus.w_en   = wr_en;
    assign bus.ack0   = wr_en & ~owner_q;
    assign bus.ack1   = wr_en &  owner_q;
    assign bus.w_data = owner_q ? bus.data1 : bus.data0;
    assign bus.busy   = (state_q == BURST);
    assign bus.owner  = owner_q;

    a_ack_onehot : assert property (@(posedge clk_w) disable iff (!rst_w)
        !(bus.ack0 && bus.ack1));

    a_wen_not_full : assert property (@(posedge clk_w) disable iff (!rst_w)
        bus.w_en |-> !bus.full);

    a_wen_in_burst : assert property (@(posedge clk_w) disable iff (!rst_w)
        bus.w_en |-> bus.busy);

endmodule
